// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-style request arbiter: data has fixed priority, a grant is held
// until its address is accepted, and an in-order ID queue routes each response.
module sram_req_arbiter #(
  parameter int MAX_OUT = 2,
  localparam int CW = $clog2(MAX_OUT + 1),
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [3:0]    inst_wstrb,
  input  logic [31:0]   inst_addr,
  input  logic [31:0]   inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [3:0]    data_wstrb,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [3:0]    bus_wstrb,
  output logic [31:0]   bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [31:0]   bus_rdata,
  output logic          arb_err,
  output logic [1:0]    o_dbg_state,
  output logic [CW-1:0] o_dbg_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ids [MAX_OUT];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_err;

  logic w_gnt_data;
  logic w_gnt_req;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake: a request is transferred on any cycle where bus_req and bus_addr_ok
  // are both high; the requester holds *_req and its fields until its *_addr_ok.
  always_comb begin
    w_gnt_data = 1'b0;
    case (r_state)
      ST_IDLE:   w_gnt_data = data_req;
      ST_LOCK_I: w_gnt_data = 1'b0;
      ST_LOCK_D: w_gnt_data = 1'b1;
      default:   w_gnt_data = data_req;
    endcase
  end

  assign w_gnt_req = w_gnt_data ? data_req : inst_req;
  assign w_full    = (r_count == CW'(MAX_OUT));
  assign w_empty   = (r_count == '0);
  assign w_head_id = r_ids[r_head];

  assign bus_req   = w_gnt_req & ~w_full;
  assign bus_wr    = w_gnt_data ? data_wr    : inst_wr;
  assign bus_size  = w_gnt_data ? data_size  : inst_size;
  assign bus_wstrb = w_gnt_data ? data_wstrb : inst_wstrb;
  assign bus_addr  = w_gnt_data ? data_addr  : inst_addr;
  assign bus_wdata = w_gnt_data ? data_wdata : inst_wdata;

  assign w_push = bus_req & bus_addr_ok;
  assign w_pop  = bus_data_ok & ~w_empty;

  assign inst_addr_ok = w_push & ~w_gnt_data;
  assign data_addr_ok = w_push &  w_gnt_data;
  assign inst_data_ok = w_pop  & ~w_head_id;
  assign data_data_ok = w_pop  &  w_head_id;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign arb_err     = r_err;
  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

  // A presented but unaccepted request freezes the grant on its owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (bus_req & ~bus_addr_ok)
            r_state <= w_gnt_data ? ST_LOCK_D : ST_LOCK_I;
        ST_LOCK_I:
          if (~inst_req | w_push) r_state <= ST_IDLE;
        ST_LOCK_D:
          if (~data_req | w_push) r_state <= ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) r_ids[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_ids[r_tail] <= w_gnt_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) r_head <= ptr_inc(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding means the bus and queue disagree.
      if (bus_data_ok & w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a queue-based model checks every output each
// cycle, and literal expectations pin the headline scenarios.
module tb_sram_req_arbiter;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;
  logic        arb_err;
  logic [1:0]  o_dbg_state;
  logic [1:0]  o_dbg_count;

  int n_total = 0;
  int n_bad   = 0;

  sram_req_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .arb_err(arb_err), .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: exp_q holds requester IDs (0 inst, 1 data) in acceptance order.
  logic [0:0] exp_q[$];
  int         m_lock = -1;
  bit         m_err  = 1'b0;
  bit         m_live = 1'b0;

  always @(negedge clk) begin
    int own;
    bit ereq, acc, pop, hid, full;
    if (reset) begin
      exp_q.delete();
      m_lock = -1;
      m_err  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (m_lock >= 0) own = m_lock;
      else if (data_req) own = 1;
      else if (inst_req) own = 0;
      else own = -1;
      full = (exp_q.size() == MAX_OUT);
      ereq = ((own == 1 && data_req) || (own == 0 && inst_req)) && !full;
      acc  = ereq && bus_addr_ok;
      pop  = bus_data_ok && (exp_q.size() > 0);
      hid  = pop ? exp_q[0][0] : 1'b0;

      chk("m_bus_req", {31'd0, bus_req}, {31'd0, ereq});
      chk("m_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && own == 0});
      chk("m_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && own == 1});
      chk("m_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, pop && !hid});
      chk("m_data_data_ok", {31'd0, data_data_ok}, {31'd0, pop && hid});
      chk("m_inst_rdata", inst_rdata, bus_rdata);
      chk("m_data_rdata", data_rdata, bus_rdata);
      chk("m_arb_err", {31'd0, arb_err}, {31'd0, m_err});
      chk("m_count", {30'd0, o_dbg_count}, exp_q.size());
      if (ereq) begin
        chk("m_bus_addr", bus_addr, (own == 1) ? data_addr : inst_addr);
        chk("m_bus_wdata", bus_wdata, (own == 1) ? data_wdata : inst_wdata);
        chk("m_bus_ctl", {25'd0, bus_wr, bus_size, bus_wstrb},
            (own == 1) ? {25'd0, data_wr, data_size, data_wstrb}
                       : {25'd0, inst_wr, inst_size, inst_wstrb});
      end

      if (bus_data_ok && exp_q.size() == 0) m_err = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(own[0]);
      if (m_lock >= 0) begin
        if (!((m_lock == 1) ? data_req : inst_req) || acc) m_lock = -1;
      end else if (ereq && !bus_addr_ok) begin
        m_lock = own;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_arb_err", {31'd0, arb_err}, 32'd0);
    chk("rst_count", {30'd0, o_dbg_count}, 32'd0);
    chk("rst_state", {30'd0, o_dbg_state}, 32'd0);

    // Simultaneous requests: data wins, inst follows next cycle.
    inst_req = 1; inst_addr = 32'h1C00_0000;
    data_req = 1; data_addr = 32'h0000_1000; data_wr = 1; data_wstrb = 4'hF;
    data_wdata = 32'hDEAD_BEEF; bus_addr_ok = 1;
    #1;
    chk("prio_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("prio_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("prio_bus_addr", bus_addr, 32'h0000_1000);
    chk("prio_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    step();
    data_req = 0; data_wr = 0;
    #1;
    chk("prio_next_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("prio_next_addr", bus_addr, 32'h1C00_0000);
    step();
    inst_req = 0; bus_addr_ok = 0;
    #1 chk("prio_count2", {30'd0, o_dbg_count}, 32'd2);
    bus_data_ok = 1; bus_rdata = 32'h1111_1111;
    #1 chk("prio_resp_data", {31'd0, data_data_ok}, 32'd1);
    step();
    bus_rdata = 32'h2222_2222;
    #1 chk("prio_resp_inst", {31'd0, inst_data_ok}, 32'd1);
    step();
    bus_data_ok = 0;

    // Locked grant survives a late data request.
    inst_req = 1; inst_addr = 32'h1C00_0040;
    #1 chk("lock_c1_addr", bus_addr, 32'h1C00_0040);
    step();
    data_req = 1; data_addr = 32'h0000_2000;
    #1 chk("lock_c2_addr", bus_addr, 32'h1C00_0040);
    chk("lock_state", {30'd0, o_dbg_state}, 32'd1);
    step();
    #1 chk("lock_c3_addr", bus_addr, 32'h1C00_0040);
    step();
    bus_addr_ok = 1;
    #1 chk("lock_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("lock_data_not_ok", {31'd0, data_addr_ok}, 32'd0);
    step();
    inst_req = 0;
    #1 chk("lock_then_data_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("lock_then_addr", bus_addr, 32'h0000_2000);
    step();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    step();
    step();
    bus_data_ok = 0;

    // In-order response routing.
    inst_req = 1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_1000;
    step();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hAAAA_0000;
    #1 chk("route_inst_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("route_inst_rdata", inst_rdata, 32'hAAAA_0000);
    chk("route_data_quiet", {31'd0, data_data_ok}, 32'd0);
    step();
    bus_rdata = 32'h5555_FFFF;
    #1 chk("route_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("route_data_rdata", data_rdata, 32'h5555_FFFF);
    chk("route_inst_quiet", {31'd0, inst_data_ok}, 32'd0);
    step();
    bus_data_ok = 0;

    // Full queue blocks; a same-cycle pop does not unblock.
    inst_req = 1; bus_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_3000;
    step();
    #1 chk("full_bus_req", {31'd0, bus_req}, 32'd0);
    chk("full_no_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    bus_data_ok = 1;
    #1 chk("full_pop_still_blocked", {31'd0, bus_req}, 32'd0);
    step();
    bus_data_ok = 0;
    #1 chk("full_reissue", {31'd0, bus_req}, 32'd1);
    chk("full_reissue_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    step();
    step();
    bus_data_ok = 0;

    // Push and pop together at count 1 across pointer wrap.
    inst_req = 1; inst_addr = 32'h1C00_0100; bus_addr_ok = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      inst_req = (i % 2 == 0); data_req = (i % 2 == 1);
      inst_addr = 32'h1C00_0200 + 32'(i * 4);
      data_addr = 32'h0000_4000 + 32'(i * 4);
      bus_data_ok = 1; bus_rdata = 32'(i);
      #1 chk("wrap_count", {30'd0, o_dbg_count}, 32'd1);
      step();
    end
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1 chk("wrap_last_data", {31'd0, data_data_ok}, 32'd1);
    step();
    bus_data_ok = 0;
    #1 chk("wrap_empty", {30'd0, o_dbg_count}, 32'd0);

    // Response with nothing outstanding is sticky until reset.
    bus_data_ok = 1;
    #1 chk("err_no_inst_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("err_no_data_ok", {31'd0, data_data_ok}, 32'd0);
    step();
    bus_data_ok = 0;
    #1 chk("err_set", {31'd0, arb_err}, 32'd1);
    step();
    step();
    chk("err_sticky", {31'd0, arb_err}, 32'd1);
    reset = 1;
    step();
    reset = 0;
    #1 chk("err_cleared", {31'd0, arb_err}, 32'd0);

    // Reset mid-flight: the late response finds an empty queue.
    inst_req = 1; bus_addr_ok = 1;
    step();
    inst_req = 0; bus_addr_ok = 0; reset = 1;
    step();
    reset = 0; bus_data_ok = 1;
    #1 chk("midrst_no_ok", {31'd0, inst_data_ok}, 32'd0);
    step();
    bus_data_ok = 0;
    #1 chk("midrst_err", {31'd0, arb_err}, 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
